// File: rtl/rr_req_arbiter_8.sv
// Round-robin arbiter for 8 request lines. It feeds the 8-to-3 encoder with a
// registered grant that is either zero or one-hot, plus a matching enable.
// Each grant is held until the owner sends done, the owner drops its request,
// or the hold timeout expires. A one-cycle gap with grant=0 always follows a release.
module rr_req_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_en,
    output logic       timeout,
    output logic [2:0] ptr
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    // Last counter value before a forced release. It is unused when MAX_HOLD is 0.
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic             HoldOn   = (MAX_HOLD != 0);

    state_e           state_q;
    logic [7:0]       grant_q;
    logic             grant_en_q;
    logic             timeout_q;
    logic [2:0]       ptr_q;
    logic [2:0]       owner_q;
    logic [CNT_W-1:0] cnt_q;

    logic       win_valid;
    logic [2:0] win_idx;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_hold;
    logic       release_now;

    // Find the first set request, scanning upward from ptr and wrapping from 7 to 0.
    // The loop runs from the highest offset down, so the lowest offset is written last and wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                win_valid = 1'b1;
                win_idx   = ptr_q + 3'(i);
            end
        end
    end

    // Release conditions for the current owner, evaluated on every edge in GRANT.
    always_comb begin
        rel_done    = done;
        rel_drop    = ~req[owner_q];
        rel_hold    = HoldOn && (cnt_q == HoldLast);
        release_now = rel_done | rel_drop | rel_hold;
    end

    // Single-process FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= 8'h00;
            grant_en_q <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= 3'd0;
            owner_q    <= 3'd0;
            cnt_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en && win_valid) begin
                        grant_q    <= 8'b1 << win_idx;
                        grant_en_q <= 1'b1;
                        owner_q    <= win_idx;
                        cnt_q      <= '0;
                        state_q    <= StGrant;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        grant_q    <= 8'h00;
                        grant_en_q <= 1'b0;
                        ptr_q      <= owner_q + 3'd1;
                        // A done or a request drop in the same cycle takes priority over the timeout.
                        timeout_q  <= rel_hold & ~rel_done & ~rel_drop;
                        state_q    <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign grant_en = grant_en_q;
    assign timeout  = timeout_q;
    assign ptr      = ptr_q;

endmodule

// File: tb/tb_rr_req_arbiter_8.sv
// Directed bench for rr_req_arbiter_8. Each step pushes the outputs it expects
// after the next edge onto a scoreboard, then pops them and compares.
module tb_rr_req_arbiter_8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_en;
    logic       timeout;
    logic [2:0] ptr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] grant;
        logic       grant_en;
        logic       timeout;
        logic [2:0] ptr;
    } exp_t;

    exp_t sb[$];

    rr_req_arbiter_8 #(
        .MAX_HOLD(16),
        .CNT_W   (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .grant_en(grant_en),
        .timeout (timeout),
        .ptr     (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: stop the run if it is still going long after the last step.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [7:0] g, input logic to, input logic [2:0] p);
        exp_t e;
        e.tag      = tag;
        e.grant    = g;
        e.grant_en = (g != 8'h00);
        e.timeout  = to;
        e.ptr      = p;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty got=0 entries required=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (grant === e.grant) else begin
            failures++;
            $error("FAIL %s grant got=%h required=%h", e.tag, grant, e.grant);
        end
        checks++;
        assert (grant_en === e.grant_en) else begin
            failures++;
            $error("FAIL %s grant_en got=%b required=%b", e.tag, grant_en, e.grant_en);
        end
        checks++;
        assert (timeout === e.timeout) else begin
            failures++;
            $error("FAIL %s timeout got=%b required=%b", e.tag, timeout, e.timeout);
        end
        checks++;
        assert (ptr === e.ptr) else begin
            failures++;
            $error("FAIL %s ptr got=%0d required=%0d", e.tag, ptr, e.ptr);
        end
    endtask

    // Expect the given outputs after the next rising edge, and sample them 1 time unit later.
    task automatic step(input string tag, input logic [7:0] g, input logic to, input logic [2:0] p);
        push(tag, g, to, p);
        @(posedge clk);
        #1;
        check_front();
    endtask

    // Run one grant, release it with done, then step through the gap cycle.
    task automatic grant_cycle(input string tag, input logic [7:0] g, input logic [2:0] p,
                               input logic [2:0] pn);
        step({tag, "_grant"}, g, 1'b0, p);
        done = 1'b1;
        step({tag, "_rel"}, 8'h00, 1'b0, pn);
        done = 1'b0;
        step({tag, "_gap"}, 8'h00, 1'b0, pn);
    endtask

    // Assert reset between clock edges and check that the outputs clear without an edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        push(tag, 8'h00, 1'b0, 3'd0);
        check_front();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        #12;
        push("reset", 8'h00, 1'b0, 3'd0);
        check_front();
        rst = 1'b0;

        // Single request after reset.
        en  = 1'b1;
        req = 8'h04;
        grant_cycle("single", 8'h04, 3'd0, 3'd3);
        req = 8'h00;

        // Round robin with every line requesting.
        async_reset("rst_rr");
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            grant_cycle("rr", 8'h01 << (k % 8), 3'(k % 8), 3'((k + 1) % 8));
        end

        // Wrap-around: start the scan at 6 and find bit 0.
        async_reset("rst_wrap");
        req = 8'h20;
        grant_cycle("wrap_pre", 8'h20, 3'd0, 3'd6);
        req = 8'h21;
        grant_cycle("wrap", 8'h01, 3'd6, 3'd1);

        // Timeout after holding the grant for 16 cycles.
        req = 8'h10;
        step("to_grant", 8'h10, 1'b0, 3'd1);
        for (int i = 0; i < 15; i++) step("to_hold", 8'h10, 1'b0, 3'd1);
        step("to_fire", 8'h00, 1'b1, 3'd5);
        step("to_gap", 8'h00, 1'b0, 3'd5);
        step("to_regrant", 8'h10, 1'b0, 3'd5);

        // A done on the timeout cycle suppresses the timeout pulse.
        for (int i = 0; i < 15; i++) step("tod_hold", 8'h10, 1'b0, 3'd5);
        done = 1'b1;
        step("tod_rel", 8'h00, 1'b0, 3'd5);
        done = 1'b0;
        step("tod_gap", 8'h00, 1'b0, 3'd5);

        // The owner drops its request during the grant.
        step("drop_grant", 8'h10, 1'b0, 3'd5);
        step("drop_hold", 8'h10, 1'b0, 3'd5);
        req = 8'h00;
        step("drop_rel", 8'h00, 1'b0, 3'd5);
        step("drop_gap", 8'h00, 1'b0, 3'd5);

        // With en low, no grant is issued even though requests are pending.
        en  = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 3; i++) step("en_off", 8'h00, 1'b0, 3'd5);
        en = 1'b1;
        step("en_on", 8'h20, 1'b0, 3'd5);
        en = 1'b0;
        step("en_drop_keep", 8'h20, 1'b0, 3'd5);
        req = 8'h21;
        step("nonowner_chg", 8'h20, 1'b0, 3'd5);
        done = 1'b1;
        step("en_rel", 8'h00, 1'b0, 3'd6);
        done = 1'b0;
        step("en_gap", 8'h00, 1'b0, 3'd6);

        // Reset arrives while bit 7 holds the grant.
        en  = 1'b1;
        req = 8'h80;
        step("g80", 8'h80, 1'b0, 3'd6);
        async_reset("rst_mid");
        req = 8'h81;
        step("post_rst", 8'h01, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
